// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants and types for the 3x3 Calculator datapath.
// Used by the operand loader, Calculator and their benches.
package matrix_pkg;

    localparam int MAT_DIM    = 3;
    localparam int MAT_ELEMS  = 9;
    localparam int LOAD_ELEMS = 18;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        LOAD,
        FIRE,
        HOLD
    } ld_state_e;

    // Stream position 0..17 -> slot 0..8 inside the A or B bank.
    function automatic logic [3:0] bank_idx(input logic [4:0] k);
        return (k < 5'(MAT_ELEMS)) ? k[3:0] : 4'(k - 5'(MAT_ELEMS));
    endfunction

endpackage

// File: rtl/mat3_reg_bank.sv
// mat3_reg_bank: nine DATA_W registers holding one row-major 3x3 matrix.
// Ports: clk, rst_n (async low), clr_i (sync zero), we_i/idx_i/d_i write, q_o all slots.
module mat3_reg_bank
    import matrix_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr_i,
    input  logic                              we_i,
    input  logic [3:0]                        idx_i,
    input  logic [DATA_W-1:0]                 d_i,
    output logic [MAT_ELEMS-1:0][DATA_W-1:0]  q_o
);

    logic [MAT_ELEMS-1:0][DATA_W-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (clr_i) begin
            mem_q <= '0;
        end else if (we_i) begin
            for (int i = 0; i < MAT_ELEMS; i++) begin
                if (idx_i == 4'(i)) begin
                    mem_q[i] <= d_i;
                end
            end
        end
    end

    assign q_o = mem_q;

endmodule

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: streams 18 elements into A/B banks, fires the multiplier,
// then holds result_valid until acked. Ports: in_* handshake, A00..B22, enable/valid/ack, elem_count.
module matrix_operand_loader
    import matrix_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MULT_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] A00, A01, A02,
    output logic [DATA_W-1:0] A10, A11, A12,
    output logic [DATA_W-1:0] A20, A21, A22,
    output logic [DATA_W-1:0] B00, B01, B02,
    output logic [DATA_W-1:0] B10, B11, B12,
    output logic [DATA_W-1:0] B20, B21, B22,
    output logic              enable_multiplication,
    output logic              result_valid,
    input  logic              result_ack,
    output logic [4:0]        elem_count
);

    if (MULT_LATENCY < 1) begin : g_bad_latency
        $error("MULT_LATENCY must be >= 1");
    end

    localparam int LAT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MULT_LATENCY - 1);

    ld_state_e  state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;

    logic       accept;
    logic       in_b;
    logic [3:0] widx;
    logic [MAT_ELEMS-1:0][DATA_W-1:0] a_q, b_q;

    // clear wins over an element arriving in the same cycle.
    assign in_ready = (state_q == LOAD);
    assign accept   = in_valid & in_ready & ~clear;
    assign in_b     = (cnt_q >= 5'(MAT_ELEMS));
    assign widx     = bank_idx(cnt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(LOAD_ELEMS - 1)) begin
                        state_d = FIRE;
                        lat_d   = LAT_INIT;
                    end
                end
            end
            FIRE: begin
                if (lat_q == '0) begin
                    state_d = HOLD;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            HOLD: begin
                if (result_ack) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            default: state_d = LOAD;
        endcase
        if (clear) begin
            state_d = LOAD;
            cnt_d   = '0;
            lat_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    mat3_reg_bank #(.DATA_W(DATA_W)) u_bank_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clear),
        .we_i  (accept & ~in_b),
        .idx_i (widx),
        .d_i   (in_data),
        .q_o   (a_q)
    );

    mat3_reg_bank #(.DATA_W(DATA_W)) u_bank_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clear),
        .we_i  (accept & in_b),
        .idx_i (widx),
        .d_i   (in_data),
        .q_o   (b_q)
    );

    // Decoded from state flops only, so reset drops them immediately.
    assign enable_multiplication = (state_q == FIRE);
    assign result_valid          = (state_q == HOLD);
    assign elem_count            = cnt_q;

    assign A00 = a_q[0];
    assign A01 = a_q[1];
    assign A02 = a_q[2];
    assign A10 = a_q[3];
    assign A11 = a_q[4];
    assign A12 = a_q[5];
    assign A20 = a_q[6];
    assign A21 = a_q[7];
    assign A22 = a_q[8];
    assign B00 = b_q[0];
    assign B01 = b_q[1];
    assign B02 = b_q[2];
    assign B10 = b_q[3];
    assign B11 = b_q[4];
    assign B12 = b_q[5];
    assign B20 = b_q[6];
    assign B21 = b_q[7];
    assign B22 = b_q[8];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader: directed bench, loaders with MULT_LATENCY 1 and 3 on shared inputs.
// A small 3x3 product of the operand outputs stands in for Calculator.
module tb_matrix_operand_loader;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic        result_ack;

    logic        rdy1, en1, rv1;
    logic        rdy3, en3, rv3;
    logic [4:0]  cnt1, cnt3;
    wire [8:0][15:0] a1, b1, a3, b3;

    int n_tests;
    int n_fail;

    logic [15:0] v1 [18] = '{1, 0, 0, 0, 1, 0, 0, 0, 1,
                             2, 3, 4, 1, 0, 6, 7, 5, 1};
    logic [15:0] v2 [18] = '{1, 2, 3, 4, 5, 6, 7, 8, 9,
                             9, 8, 7, 6, 5, 4, 3, 2, 1};
    logic [31:0] r1 [9]  = '{2, 3, 4, 1, 0, 6, 7, 5, 1};
    logic [31:0] r2 [9]  = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

    matrix_operand_loader #(.DATA_W(16), .MULT_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
        .A00(a1[0]), .A01(a1[1]), .A02(a1[2]),
        .A10(a1[3]), .A11(a1[4]), .A12(a1[5]),
        .A20(a1[6]), .A21(a1[7]), .A22(a1[8]),
        .B00(b1[0]), .B01(b1[1]), .B02(b1[2]),
        .B10(b1[3]), .B11(b1[4]), .B12(b1[5]),
        .B20(b1[6]), .B21(b1[7]), .B22(b1[8]),
        .enable_multiplication(en1), .result_valid(rv1),
        .result_ack(result_ack), .elem_count(cnt1)
    );

    matrix_operand_loader #(.DATA_W(16), .MULT_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy3),
        .A00(a3[0]), .A01(a3[1]), .A02(a3[2]),
        .A10(a3[3]), .A11(a3[4]), .A12(a3[5]),
        .A20(a3[6]), .A21(a3[7]), .A22(a3[8]),
        .B00(b3[0]), .B01(b3[1]), .B02(b3[2]),
        .B10(b3[3]), .B11(b3[4]), .B12(b3[5]),
        .B20(b3[6]), .B21(b3[7]), .B22(b3[8]),
        .enable_multiplication(en3), .result_valid(rv3),
        .result_ack(result_ack), .elem_count(cnt3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rmul(input int i, input int j);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 3; k++) begin
            s += 32'(a1[i*3+k]) * 32'(b1[k*3+j]);
        end
        return s;
    endfunction

    task automatic check_r(input logic [31:0] exp [9]);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("R%0d%0d", i, j), rmul(i, j), exp[i*3+j]);
            end
        end
    endtask

    task automatic push(input logic [15:0] d, input int gap, input int cnt);
        bit done;
        done = 1'b0;
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 40 && !done; n++) begin
            if (rdy1) done = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk($sformatf("accept%0d", cnt), 32'(done), 1);
        chk($sformatf("elem_count%0d", cnt), 32'(cnt1), 32'(cnt));
    endtask

    task automatic load(input logic [15:0] v [18], input bit gaps);
        for (int k = 0; k < 18; k++) begin
            push(v[k], gaps ? int'($urandom_range(0, 2)) : 0, k + 1);
        end
    endtask

    task automatic fire_wait();
        int   en1c;
        int   en3c;
        int   cyc;
        logic prev3;
        chk("fire_en1", 32'(en1), 1);
        chk("fire_rdy", 32'(rdy1), 0);
        chk("fire_rv1", 32'(rv1), 0);
        chk("fire_cnt", 32'(cnt1), 18);
        en1c  = 1;
        en3c  = en3 ? 1 : 0;
        prev3 = en3;
        cyc   = 0;
        while (!rv3 && cyc < 20) begin
            prev3 = en3;
            step();
            cyc++;
            en1c += en1 ? 1 : 0;
            en3c += en3 ? 1 : 0;
        end
        chk("en1_cycles", 32'(en1c), 1);
        chk("en3_cycles", 32'(en3c), 3);
        chk("rv3_rise", 32'(rv3), 1);
        chk("en3_before_rv3", 32'(prev3), 1);
        chk("en3_low_in_hold", 32'(en3), 0);
        chk("rv1_hold", 32'(rv1), 1);
        chk("rdy_hold", 32'(rdy1), 0);
    endtask

    task automatic ack();
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk("ack_rdy", 32'(rdy1), 1);
        chk("ack_rv", 32'(rv1), 0);
        chk("ack_cnt", 32'(cnt1), 0);
        in_valid = 1'b0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        result_ack = 1'b0;

        #3;
        chk("rst_rdy", 32'(rdy1), 1);
        chk("rst_en", 32'(en1), 0);
        chk("rst_rv", 32'(rv1), 0);
        chk("rst_cnt", 32'(cnt1), 0);
        chk("rst_ops", 32'(|{a1, b1}), 0);
        #5;
        rst_n = 1'b1;
        step();

        // identity A, checks latency windows of both loaders
        load(v1, 1'b0);
        fire_wait();
        chk("A00", 32'(a1[0]), 1);
        chk("A01", 32'(a1[1]), 0);
        chk("A11", 32'(a1[4]), 1);
        chk("A22", 32'(a1[8]), 1);
        chk("B01", 32'(b1[1]), 3);
        chk("B12", 32'(b1[5]), 6);
        check_r(r1);
        ack();

        // gapped stream, then 0xFFFF held on in_valid through FIRE/HOLD
        load(v2, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        fire_wait();
        chk("hold_A22", 32'(a1[8]), 9);
        chk("hold_B00", 32'(b1[0]), 9);
        chk("hold_B22", 32'(b1[8]), 1);
        check_r(r2);
        ack();

        // clear with an element pending at elem_count=10
        for (int k = 0; k < 10; k++) push(v2[k], 0, k + 1);
        in_valid = 1'b1;
        in_data  = 16'h0055;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_cnt", 32'(cnt1), 0);
        chk("clr_rdy", 32'(rdy1), 1);
        chk("clr_ops", 32'(|{a1, b1}), 0);
        chk("clr_ops3", 32'(|{a3, b3}), 0);
        load(v1, 1'b0);
        fire_wait();
        check_r(r1);
        ack();

        // async reset while firing
        load(v2, 1'b0);
        chk("pre_rst_en", 32'(en1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en1", 32'(en1), 0);
        chk("arst_en3", 32'(en3), 0);
        chk("arst_rv1", 32'(rv1), 0);
        chk("arst_rv3", 32'(rv3), 0);
        chk("arst_rdy", 32'(rdy1), 1);
        chk("arst_cnt", 32'(cnt1), 0);
        chk("arst_ops", 32'(|{a1, b1}), 0);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_en", 32'(en1), 0);
        chk("post_rst_rdy", 32'(rdy1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
